// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the Forth core.
// Holds the PC and picks the next value from NEXT/JMP/BZ/CALL/RET/HOLD.
// A small LIFO keeps return addresses for CALL/RET. Overflow and underflow
// of that stack are recorded in sticky flags that only Rst clears.
module pc_sequencer #(
  parameter int              AW        = 16,
  parameter int              RS_DEPTH  = 16,
  parameter logic [AW-1:0]   RESET_VEC = '0
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Stall,
  input  logic [2:0]                    Op,
  input  logic [AW-1:0]                 Target,
  input  logic                          Cond,
  output logic [AW-1:0]                 PC,
  output logic [AW-1:0]                 RsTop,
  output logic [$clog2(RS_DEPTH+1)-1:0] RsCount,
  output logic                          RsOvf,
  output logic                          RsUnf
);

  localparam int CW = $clog2(RS_DEPTH+1);
  localparam int PW = $clog2(RS_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_BZ   = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_HOLD = 3'b101
  } op_t;

  logic [AW-1:0] pc_q, pc_next, pc_inc, rs_top;
  logic [CW-1:0] cnt_q, cnt_next, cnt_m1;
  logic [PW-1:0] top_idx;
  logic          ovf_q, ovf_next, unf_q, unf_next;
  logic          push, full, empty;
  logic [AW-1:0] stack [RS_DEPTH];

  // Values derived from state only; the stack top never sees the inputs.
  assign pc_inc  = pc_q + AW'(1);
  assign full    = (cnt_q == CW'(RS_DEPTH));
  assign empty   = (cnt_q == '0);
  assign cnt_m1  = cnt_q - CW'(1);
  assign top_idx = cnt_m1[PW-1:0];
  assign rs_top  = empty ? '0 : stack[top_idx];

  // Next-PC, stack pointer and flag selection for the current operation.
  always_comb begin
    pc_next  = pc_q;
    cnt_next = cnt_q;
    push     = 1'b0;
    ovf_next = ovf_q;
    unf_next = unf_q;
    case (Op)
      OP_JMP:  pc_next = Target;
      OP_BZ:   pc_next = Cond ? Target : pc_inc;
      OP_CALL: begin
        pc_next = Target;
        if (full) begin
          ovf_next = 1'b1;
        end else begin
          push     = 1'b1;
          cnt_next = cnt_q + CW'(1);
        end
      end
      OP_RET: begin
        if (empty) begin
          pc_next  = pc_inc;
          unf_next = 1'b1;
        end else begin
          pc_next  = rs_top;
          cnt_next = cnt_m1;
        end
      end
      OP_HOLD: pc_next = pc_q;
      default: pc_next = pc_inc;
    endcase
  end

  // Control state: reset beats stall, stall freezes everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!Stall) begin
      pc_q  <= pc_next;
      cnt_q <= cnt_next;
      ovf_q <= ovf_next;
      unf_q <= unf_next;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge Clk) begin
    if (!Rst && !Stall && push) begin
      stack[cnt_q[PW-1:0]] <= pc_inc;
    end
  end

  assign PC      = pc_q;
  assign RsTop   = rs_top;
  assign RsCount = cnt_q;
  assign RsOvf   = ovf_q;
  assign RsUnf   = unf_q;

endmodule
